// File: rtl/exu_div_pipe1.sv
// exu_div_pipe1: iterative RV64M divider fed by pipe1 register-read.
// Executes DIV/DIVU/REM/REMU and their W forms with one restoring
// shift/subtract step per cycle, then drives the EX forward bus, the
// CDB bus one cycle later, and a completion pulse to the RTU.
module exu_div_pipe1 #(
  parameter int XLEN   = 64,
  parameter int PREG_W = 6,
  parameter int IID_W  = 5
) (
  input  logic              clk,
  input  logic              rst_clk,
  input  logic              rtu_global_flush,
  input  logic              pipe1_vld,
  input  logic [IID_W-1:0]  pipe1_iid,
  input  logic [6:0]        pipe1_opcode,
  input  logic [6:0]        pipe1_funct7,
  input  logic [2:0]        pipe1_funct3,
  input  logic [XLEN-1:0]   pipe1_psrc1_value,
  input  logic [XLEN-1:0]   pipe1_psrc2_value,
  input  logic              pipe1_pdst_vld,
  input  logic [PREG_W-1:0] pipe1_pdst,
  output logic              div_busy,
  output logic              exu_idu_rf_div_ex_vld,
  output logic [PREG_W-1:0] exu_idu_rf_div_ex_preg,
  output logic [XLEN-1:0]   exu_idu_rf_div_ex_result,
  output logic              exu_idu_rf_div_cdb_vld,
  output logic [PREG_W-1:0] exu_idu_rf_div_cdb_preg,
  output logic [XLEN-1:0]   exu_idu_rf_div_cdb_result,
  output logic              exu_rtu_div_cmplt_vld,
  output logic [IID_W-1:0]  exu_rtu_div_cmplt_iid
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_EX   = 2'd2,
    S_CDB  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // captured op context
  logic [IID_W-1:0]  iid_reg;
  logic [PREG_W-1:0] pdst_reg;
  logic              pdst_vld_reg;
  logic              is_w_reg;
  logic              is_rem_reg;
  logic              q_neg_reg;
  logic              r_neg_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [XLEN-1:0]   quo_reg;
  logic [XLEN-1:0]   rem_reg;
  logic [XLEN-1:0]   div_reg;
  logic [XLEN-1:0]   result_reg;

  // accept decode
  logic is_div_op, accept, acc_w, acc_sgn, acc_rem;
  assign is_div_op = pipe1_vld & (pipe1_funct7 == 7'b0000001) & pipe1_funct3[2] &
                     ((pipe1_opcode == 7'b0110011) | (pipe1_opcode == 7'b0111011));
  assign acc_w     = (pipe1_opcode == 7'b0111011);
  assign acc_sgn   = ~pipe1_funct3[0];
  assign acc_rem   = pipe1_funct3[1];
  // flush beats a coincident accept; a busy unit silently drops the op
  assign accept    = is_div_op & (state_reg == S_IDLE) & ~rtu_global_flush;

  // operand preparation: width-extend, take magnitudes, detect special cases
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, a_res, spec_result;
  logic            a_neg, b_neg, b_zero, ovf, is_special;

  // Extend operands to XLEN and resolve special-case results at accept time
  always_comb begin
    a_ext = pipe1_psrc1_value;
    b_ext = pipe1_psrc2_value;
    if (acc_w) begin
      a_ext = {{(XLEN-32){acc_sgn & pipe1_psrc1_value[31]}}, pipe1_psrc1_value[31:0]};
      b_ext = {{(XLEN-32){acc_sgn & pipe1_psrc2_value[31]}}, pipe1_psrc2_value[31:0]};
    end
    a_neg  = acc_sgn & a_ext[XLEN-1];
    b_neg  = acc_sgn & b_ext[XLEN-1];
    a_abs  = a_neg ? -a_ext : a_ext;
    b_abs  = b_neg ? -b_ext : b_ext;
    b_zero = (b_ext == '0);
    if (acc_w)
      ovf = acc_sgn & (pipe1_psrc1_value[31:0] == 32'h8000_0000) &
            (pipe1_psrc2_value[31:0] == 32'hFFFF_FFFF);
    else
      ovf = acc_sgn & (pipe1_psrc1_value == MOST_NEG) & (pipe1_psrc2_value == '1);
    is_special = b_zero | ovf;
    // W results are always the sign-extended low word
    a_res = acc_w ? {{(XLEN-32){pipe1_psrc1_value[31]}}, pipe1_psrc1_value[31:0]}
                  : pipe1_psrc1_value;
    if (b_zero)
      spec_result = acc_rem ? a_res : '1;
    else
      spec_result = acc_rem ? '0 : a_res;
  end

  // one restoring division step plus final sign correction
  logic [XLEN:0]   rem_shift;
  logic            step_ge;
  logic [XLEN-1:0] rem_sub, rem_step, quo_step, q_raw, q_sc, r_sc, sel_res, fin_result;

  // Shift the next dividend bit into the partial remainder and try a subtract
  always_comb begin
    rem_shift  = {rem_reg, quo_reg[XLEN-1]};
    step_ge    = (rem_shift >= {1'b0, div_reg});
    // when the subtract succeeds the true difference is below div_reg, so
    // the low XLEN bits are exact
    rem_sub    = rem_shift[XLEN-1:0] - div_reg;
    rem_step   = step_ge ? rem_sub : rem_shift[XLEN-1:0];
    quo_step   = {quo_reg[XLEN-2:0], step_ge};
    q_raw      = is_w_reg ? {{(XLEN-32){1'b0}}, quo_step[31:0]} : quo_step;
    q_sc       = q_neg_reg ? -q_raw : q_raw;
    r_sc       = r_neg_reg ? -rem_step : rem_step;
    sel_res    = is_rem_reg ? r_sc : q_sc;
    fin_result = is_w_reg ? {{(XLEN-32){sel_res[31]}}, sel_res[31:0]} : sel_res;
  end

  // State register
  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state logic; flush returns to IDLE from anywhere
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (accept) state_next = is_special ? S_EX : S_CALC;
      S_CALC: if (cnt_reg == CNT_W'(1)) state_next = S_EX;
      S_EX:   state_next = S_CDB;
      S_CDB:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (rtu_global_flush)
      state_next = S_IDLE;
  end

  // Datapath: capture on accept, iterate in CALC, register the final result
  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      iid_reg      <= '0;
      pdst_reg     <= '0;
      pdst_vld_reg <= 1'b0;
      is_w_reg     <= 1'b0;
      is_rem_reg   <= 1'b0;
      q_neg_reg    <= 1'b0;
      r_neg_reg    <= 1'b0;
      cnt_reg      <= '0;
      quo_reg      <= '0;
      rem_reg      <= '0;
      div_reg      <= '0;
      result_reg   <= '0;
    end else if (accept) begin
      iid_reg      <= pipe1_iid;
      pdst_reg     <= pipe1_pdst;
      pdst_vld_reg <= pipe1_pdst_vld;
      is_w_reg     <= acc_w;
      is_rem_reg   <= acc_rem;
      q_neg_reg    <= a_neg ^ b_neg;
      r_neg_reg    <= a_neg;
      cnt_reg      <= acc_w ? CNT_W'(32) : CNT_W'(XLEN);
      // W dividends are left-aligned so every step shifts out the top bit
      quo_reg      <= acc_w ? {a_abs[31:0], {(XLEN-32){1'b0}}} : a_abs;
      rem_reg      <= '0;
      div_reg      <= b_abs;
      result_reg   <= spec_result;
    end else if (state_reg == S_CALC) begin
      quo_reg <= quo_step;
      rem_reg <= rem_step;
      cnt_reg <= cnt_reg - CNT_W'(1);
      if (cnt_reg == CNT_W'(1))
        result_reg <= fin_result;
    end
  end

  // Output decode from state; data buses are zero whenever their valid is low
  always_comb begin
    div_busy                  = (state_reg != S_IDLE);
    exu_idu_rf_div_ex_vld     = (state_reg == S_EX) & pdst_vld_reg;
    exu_idu_rf_div_cdb_vld    = (state_reg == S_CDB) & pdst_vld_reg;
    exu_rtu_div_cmplt_vld     = (state_reg == S_CDB);
    exu_idu_rf_div_ex_preg    = '0;
    exu_idu_rf_div_ex_result  = '0;
    exu_idu_rf_div_cdb_preg   = '0;
    exu_idu_rf_div_cdb_result = '0;
    exu_rtu_div_cmplt_iid     = '0;
    if (exu_idu_rf_div_ex_vld) begin
      exu_idu_rf_div_ex_preg   = pdst_reg;
      exu_idu_rf_div_ex_result = result_reg;
    end
    if (exu_idu_rf_div_cdb_vld) begin
      exu_idu_rf_div_cdb_preg   = pdst_reg;
      exu_idu_rf_div_cdb_result = result_reg;
    end
    if (exu_rtu_div_cmplt_vld)
      exu_rtu_div_cmplt_iid = iid_reg;
  end

endmodule

// File: tb/tb_exu_div_pipe1.sv
// tb_exu_div_pipe1: directed table, hand-written corner sequences and
// randomized ops checked against an arithmetic reference model.
module tb_exu_div_pipe1;

  localparam logic [6:0] OP64 = 7'b0110011;
  localparam logic [6:0] OPW  = 7'b0111011;

  logic        clk;
  logic        rst_clk;
  logic        rtu_global_flush;
  logic        pipe1_vld;
  logic [4:0]  pipe1_iid;
  logic [6:0]  pipe1_opcode;
  logic [6:0]  pipe1_funct7;
  logic [2:0]  pipe1_funct3;
  logic [63:0] pipe1_psrc1_value;
  logic [63:0] pipe1_psrc2_value;
  logic        pipe1_pdst_vld;
  logic [5:0]  pipe1_pdst;
  logic        div_busy;
  logic        ex_vld, cdb_vld, cmplt_vld;
  logic [5:0]  ex_preg, cdb_preg;
  logic [63:0] ex_result, cdb_result;
  logic [4:0]  cmplt_iid;

  int n_vec = 0;
  int n_err = 0;

  exu_div_pipe1 dut (
    .clk                       (clk),
    .rst_clk                   (rst_clk),
    .rtu_global_flush          (rtu_global_flush),
    .pipe1_vld                 (pipe1_vld),
    .pipe1_iid                 (pipe1_iid),
    .pipe1_opcode              (pipe1_opcode),
    .pipe1_funct7              (pipe1_funct7),
    .pipe1_funct3              (pipe1_funct3),
    .pipe1_psrc1_value         (pipe1_psrc1_value),
    .pipe1_psrc2_value         (pipe1_psrc2_value),
    .pipe1_pdst_vld            (pipe1_pdst_vld),
    .pipe1_pdst                (pipe1_pdst),
    .div_busy                  (div_busy),
    .exu_idu_rf_div_ex_vld     (ex_vld),
    .exu_idu_rf_div_ex_preg    (ex_preg),
    .exu_idu_rf_div_ex_result  (ex_result),
    .exu_idu_rf_div_cdb_vld    (cdb_vld),
    .exu_idu_rf_div_cdb_preg   (cdb_preg),
    .exu_idu_rf_div_cdb_result (cdb_result),
    .exu_rtu_div_cmplt_vld     (cmplt_vld),
    .exu_rtu_div_cmplt_iid     (cmplt_iid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp_res;
    int          exp_cyc;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // RISC-V M-extension semantics in plain arithmetic
  function automatic logic [63:0] ref_res(input logic w, input logic sgn, input logic rem,
                                          input logic [63:0] a, input logic [63:0] b);
    int               sa, sb;
    int unsigned      ua, ub;
    longint           la, lb;
    longint unsigned  lua, lub;
    logic [31:0]      q32, r32;
    logic [63:0]      q64, r64;
    if (w) begin
      sa = a[31:0]; sb = b[31:0]; ua = a[31:0]; ub = b[31:0];
      if (b[31:0] == 32'h0) begin
        q32 = 32'hFFFF_FFFF; r32 = a[31:0];
      end else if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
        q32 = a[31:0]; r32 = 32'h0;
      end else if (sgn) begin
        q32 = sa / sb; r32 = sa % sb;
      end else begin
        q32 = ua / ub; r32 = ua % ub;
      end
      return rem ? {{32{r32[31]}}, r32} : {{32{q32[31]}}, q32};
    end
    la = a; lb = b; lua = a; lub = b;
    if (b == 64'h0) begin
      q64 = '1; r64 = a;
    end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
      q64 = a; r64 = 64'h0;
    end else if (sgn) begin
      q64 = la / lb; r64 = la % lb;
    end else begin
      q64 = lua / lub; r64 = lua % lub;
    end
    return rem ? r64 : q64;
  endfunction

  // cycle (after accept) in which ex_vld is expected
  function automatic int ref_cyc(input logic w, input logic sgn, input logic [63:0] a,
                                 input logic [63:0] b);
    if (w) begin
      if (b[31:0] == 32'h0) return 1;
      if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    if (b == 64'h0) return 1;
    if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
    return 65;
  endfunction

  // Issue one op (caller is just after a posedge with the unit idle) and
  // watch every cycle until the unit should be idle again.
  task automatic run_op(input logic [6:0] opc, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic pv, input logic [5:0] pd, input logic [4:0] id,
                        input logic [63:0] exp_res, input int exp_cyc,
                        input int flush_cyc, input int intr_cyc);
    int ex_c, cdb_c, cm_c, end_cyc;
    logic [63:0] ex_r, cdb_r;
    logic [5:0]  ex_p, cdb_p;
    logic [4:0]  cm_i;
    logic        exp_busy;
    ex_c = 0; cdb_c = 0; cm_c = 0;
    ex_r = '0; cdb_r = '0; ex_p = '0; cdb_p = '0; cm_i = '0;
    pipe1_opcode = opc; pipe1_funct7 = 7'b0000001; pipe1_funct3 = f3;
    pipe1_psrc1_value = a; pipe1_psrc2_value = b;
    pipe1_pdst_vld = pv; pipe1_pdst = pd; pipe1_iid = id; pipe1_vld = 1'b1;
    @(posedge clk); #1;
    pipe1_vld = 1'b0;
    end_cyc = (flush_cyc > 0) ? flush_cyc + 2 : exp_cyc + 2;
    for (int cyc = 1; cyc <= end_cyc; cyc++) begin
      @(negedge clk);
      exp_busy = (flush_cyc > 0) ? (cyc <= flush_cyc) : (cyc <= exp_cyc + 1);
      chk("busy", 64'(div_busy), 64'(exp_busy));
      if (ex_vld) begin
        if (ex_c == 0) begin ex_c = cyc; ex_r = ex_result; ex_p = ex_preg; end
      end else chk("ex_idle_zero", ex_result | 64'(ex_preg), 64'h0);
      if (cdb_vld) begin
        if (cdb_c == 0) begin cdb_c = cyc; cdb_r = cdb_result; cdb_p = cdb_preg; end
      end else chk("cdb_idle_zero", cdb_result | 64'(cdb_preg), 64'h0);
      if (cmplt_vld) begin
        if (cm_c == 0) begin cm_c = cyc; cm_i = cmplt_iid; end
      end else chk("cmplt_idle_zero", 64'(cmplt_iid), 64'h0);
      rtu_global_flush = (cyc == flush_cyc);
      if (cyc == intr_cyc) begin
        pipe1_opcode = OP64; pipe1_funct3 = 3'b100; pipe1_funct7 = 7'b0000001;
        pipe1_psrc1_value = 64'h55; pipe1_psrc2_value = 64'h3;
        pipe1_pdst_vld = 1'b1; pipe1_pdst = ~pd; pipe1_iid = ~id; pipe1_vld = 1'b1;
      end else pipe1_vld = 1'b0;
    end
    rtu_global_flush = 1'b0;
    if (flush_cyc > 0) begin
      chk("flush_ex_cycle", 64'(ex_c), 64'h0);
      chk("flush_cdb_cycle", 64'(cdb_c), 64'h0);
      chk("flush_cmplt_cycle", 64'(cm_c), 64'h0);
    end else begin
      if (pv) begin
        chk("ex_cycle", 64'(ex_c), 64'(exp_cyc));
        chk("ex_result", ex_r, exp_res);
        chk("ex_preg", 64'(ex_p), 64'(pd));
        chk("cdb_cycle", 64'(cdb_c), 64'(exp_cyc + 1));
        chk("cdb_result", cdb_r, exp_res);
        chk("cdb_preg", 64'(cdb_p), 64'(pd));
      end else begin
        chk("nopdst_ex_cycle", 64'(ex_c), 64'h0);
        chk("nopdst_cdb_cycle", 64'(cdb_c), 64'h0);
      end
      chk("cmplt_cycle", 64'(cm_c), 64'(exp_cyc + 1));
      chk("cmplt_iid", 64'(cm_i), 64'(id));
    end
    $display("op opc=%b f3=%b a=%h b=%h pv=%0d ex_cyc=%0d ex=%h cmplt_cyc=%0d iid=%0d",
             opc, f3, a, b, pv, ex_c, ex_r, cm_c, cm_i);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [6:0]  r_opc;
    logic [2:0]  r_f3;
    logic [63:0] r_a, r_b;
    int          mode;

    tbl[0]  = '{OP64, 3'b100, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65};
    tbl[1]  = '{OP64, 3'b110, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    tbl[2]  = '{OPW,  3'b101, 64'h0000_0001_8000_0000, 64'd2, 64'h0000_0000_4000_0000, 33};
    tbl[3]  = '{OPW,  3'b111, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'h0000_0000_0000_000F, 33};
    tbl[4]  = '{OP64, 3'b101, 64'h1234, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    tbl[5]  = '{OPW,  3'b110, 64'h8000_0000, 64'h0, 64'hFFFF_FFFF_8000_0000, 1};
    tbl[6]  = '{OP64, 3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h8000_0000_0000_0000, 1};
    tbl[7]  = '{OP64, 3'b110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1};
    tbl[8]  = '{OPW,  3'b100, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    tbl[9]  = '{OP64, 3'b101, 64'd100, 64'd7, 64'd14, 65};
    tbl[10] = '{OP64, 3'b111, 64'd100, 64'd7, 64'd2, 65};
    tbl[11] = '{OPW,  3'b100, 64'hABCD_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};
    tbl[12] = '{OPW,  3'b110, 64'hABCD_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    tbl[13] = '{OP64, 3'b110, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65};

    rst_clk = 1'b0; rtu_global_flush = 1'b0; pipe1_vld = 1'b0; pipe1_iid = '0;
    pipe1_opcode = '0; pipe1_funct7 = '0; pipe1_funct3 = '0;
    pipe1_psrc1_value = '0; pipe1_psrc2_value = '0; pipe1_pdst_vld = 1'b0; pipe1_pdst = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(div_busy), 64'h0);
    chk("rst_vlds", 64'({ex_vld, cdb_vld, cmplt_vld}), 64'h0);
    chk("rst_data", ex_result | cdb_result | 64'(ex_preg) | 64'(cdb_preg) | 64'(cmplt_iid), 64'h0);
    @(posedge clk); #1;
    rst_clk = 1'b1;
    @(posedge clk); #1;

    // directed table
    for (int i = 0; i < 14; i++)
      run_op(tbl[i].opc, tbl[i].f3, tbl[i].a, tbl[i].b, 1'b1, 6'(i + 1), 5'(i + 2),
             tbl[i].exp_res, tbl[i].exp_cyc, 0, 0);

    // flush in cycle 20, then a fresh DIVU 100/7
    run_op(OP64, 3'b100, 64'd1000, 64'd3, 1'b1, 6'd9, 5'd9, 64'd333, 65, 20, 0);
    run_op(OP64, 3'b101, 64'd100, 64'd7, 1'b1, 6'd10, 5'd10, 64'd14, 65, 0, 0);

    // no destination: only the completion pulse
    run_op(OP64, 3'b100, 64'd50, 64'd5, 1'b0, 6'd11, 5'd11, 64'd10, 65, 0, 0);

    // ops issued while busy are dropped
    run_op(OP64, 3'b101, 64'd100, 64'd7, 1'b1, 6'd12, 5'd12, 64'd14, 65, 0, 5);
    run_op(OP64, 3'b101, 64'h1234, 64'h0, 1'b1, 6'd13, 5'd13, '1, 1, 0, 1);

    // flush coincident with accept: op not captured
    pipe1_opcode = OP64; pipe1_funct7 = 7'b0000001; pipe1_funct3 = 3'b100;
    pipe1_psrc1_value = 64'd77; pipe1_psrc2_value = 64'd0; pipe1_pdst_vld = 1'b1;
    pipe1_vld = 1'b1; rtu_global_flush = 1'b1;
    @(posedge clk); #1;
    pipe1_vld = 1'b0; rtu_global_flush = 1'b0;
    @(negedge clk);
    chk("flush_accept_busy", 64'(div_busy), 64'h0);
    @(negedge clk);
    chk("flush_accept_pulses", 64'({ex_vld, cdb_vld, cmplt_vld}), 64'h0);
    $display("flush+accept busy=%0d", div_busy);

    // non-divide ops are ignored
    @(posedge clk); #1;
    pipe1_funct3 = 3'b000; pipe1_vld = 1'b1;
    @(posedge clk); #1;
    pipe1_funct3 = 3'b100; pipe1_funct7 = 7'b0000000;
    @(posedge clk); #1;
    pipe1_funct7 = 7'b0000001; pipe1_opcode = 7'b0010011;
    @(posedge clk); #1;
    pipe1_vld = 1'b0;
    @(negedge clk);
    chk("non_div_busy", 64'(div_busy), 64'h0);
    $display("non-div ops busy=%0d", div_busy);

    // asynchronous reset mid-operation
    @(posedge clk); #1;
    pipe1_opcode = OP64; pipe1_funct7 = 7'b0000001; pipe1_funct3 = 3'b100;
    pipe1_psrc1_value = 64'd999; pipe1_psrc2_value = 64'd4; pipe1_vld = 1'b1;
    @(posedge clk); #1;
    pipe1_vld = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("mid_busy_before_rst", 64'(div_busy), 64'h1);
    rst_clk = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(div_busy), 64'h0);
    chk("mid_rst_outs", 64'({ex_vld, cdb_vld, cmplt_vld}), 64'h0);
    $display("reset mid-op busy=%0d", div_busy);
    @(posedge clk); #1;
    rst_clk = 1'b1;
    @(posedge clk); #1;
    run_op(OP64, 3'b101, 64'd100, 64'd7, 1'b1, 6'd14, 5'd14, 64'd14, 65, 0, 0);

    // randomized ops against the reference model
    for (int n = 0; n < 40; n++) begin
      r_opc = $urandom_range(0, 1) ? OPW : OP64;
      r_f3  = 3'(4 + $urandom_range(0, 3));
      mode  = $urandom_range(0, 5);
      r_a   = {$urandom, $urandom};
      r_b   = {$urandom, $urandom};
      if (mode == 0) begin
        if (r_opc == OPW) r_b[31:0] = 32'h0; else r_b = 64'h0;
      end else if (mode == 1) begin
        if (r_opc == OPW) begin r_a[31:0] = 32'h8000_0000; r_b[31:0] = 32'hFFFF_FFFF; end
        else begin r_a = 64'h8000_0000_0000_0000; r_b = '1; end
      end else if (mode == 2) begin
        r_b = {{32{r_b[63]}}, 24'h0, r_b[7:0]};
        if (r_b[31:0] == 32'h0) r_b[0] = 1'b1;
      end
      run_op(r_opc, r_f3, r_a, r_b, 1'b1, 6'($urandom), 5'($urandom),
             ref_res(r_opc == OPW, ~r_f3[0], r_f3[1], r_a, r_b),
             ref_cyc(r_opc == OPW, ~r_f3[0], r_a, r_b), 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
